// File: rtl/sim_dev_queued.sv
// Pipelined device model: up to DEPTH outstanding requests, each serviced at accept
// time and answered in order once its LATENCY countdown expires.
module sim_dev_queued #(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 1,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    output logic             in_req_ready,
    input  logic             in_req_valid,
    input  logic             in_req_bits_is_cached,
    input  logic             in_req_bits_is_aligned,
    input  logic [31:0]      in_req_bits_addr,
    input  logic [31:0]      in_req_bits_data,
    input  logic             in_req_bits_func,
    input  logic [3:0]       in_req_bits_wstrb,
    input  logic             in_resp_ready,
    output logic             in_resp_valid,
    output logic [31:0]      in_resp_bits_data,
    output logic [CNT_W-1:0] outstanding
);
    localparam int TMR_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(LATENCY - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    if (LATENCY < 1) begin : g_bad_latency
        $error("sim_dev_queued: LATENCY must be at least 1");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("sim_dev_queued: DEPTH must be at least 1");
    end

    // Behavioural stand-in for the device_io DPI-C service: reads return addr+1, writes return 0.
    function automatic logic [31:0] device_io(input logic        valid,
                                              input logic [31:0] addr,
                                              input logic [31:0] data,
                                              input logic [7:0]  func,
                                              input logic [7:0]  wstrb);
        logic unused_args;
        unused_args = ^{valid, data, func[7:1], wstrb};
        return func[0] ? 32'h0 : addr + 32'h1;
    endfunction

    logic [31:0]      data_q  [DEPTH];
    logic [TMR_W-1:0] timer_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;

    // Record of the most recent device call, read by hierarchical reference only.
    logic [31:0]      io_calls_q;
    logic [31:0]      io_addr_q;
    logic [31:0]      io_data_q;
    logic [7:0]       io_func_q;
    logic [7:0]       io_wstrb_q;
    logic             unused_sink;

    assign unused_sink = ^{in_req_bits_is_cached, in_req_bits_is_aligned, io_calls_q,
                           io_addr_q, io_data_q, io_func_q, io_wstrb_q};

    assign in_req_ready      = (count_q < CNT_FULL);
    assign in_resp_valid     = (count_q != '0) && (timer_q[head_q] == '0);
    assign in_resp_bits_data = (count_q != '0) ? data_q[head_q] : 32'h0;
    assign outstanding       = count_q;

    assign push = in_req_valid && in_req_ready && reset;
    assign pop  = in_resp_valid && in_resp_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            tail_d = (tail_q == PTR_LAST) ? '0 : tail_q + 1'b1;
        end
        if (pop) begin
            head_d = (head_q == PTR_LAST) ? '0 : head_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage: the device is called exactly once per accepted request.
    always_ff @(posedge clock) begin
        if (push) begin
            data_q[tail_q] <= device_io(1'b1, in_req_bits_addr, in_req_bits_data,
                                        {7'b0, in_req_bits_func}, {4'b0, in_req_bits_wstrb});
            io_calls_q     <= io_calls_q + 32'd1;
            io_addr_q      <= in_req_bits_addr;
            io_data_q      <= in_req_bits_data;
            io_func_q      <= {7'b0, in_req_bits_func};
            io_wstrb_q     <= {4'b0, in_req_bits_wstrb};
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (push && (tail_q == PTR_W'(i))) begin
                timer_q[i] <= TMR_INIT;
            end else if (timer_q[i] != '0) begin
                timer_q[i] <= timer_q[i] - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sim_dev_queued.sv
// Bench for sim_dev_queued: four configurations share one stimulus bus, each test
// checks the instance whose DEPTH/LATENCY it targets.
module tb_sim_dev_queued;
    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        func;
    logic [3:0]  wstrb;
    logic        resp_ready;
    logic        cached = 1'b0;
    logic        aligned = 1'b1;

    logic        rdy  [4];
    logic        vld  [4];
    logic [31:0] dat  [4];
    logic [2:0]  outs [4];

    always #5 clock = ~clock;

    // Instances: 0 = D4/L1, 1 = D4/L3, 2 = D2/L1, 3 = D3/L2
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int DP = (g == 2) ? 2 : (g == 3) ? 3 : 4;
        localparam int LT = (g == 1) ? 3 : (g == 3) ? 2 : 1;
        localparam int CW = $clog2(DP + 1);
        logic [CW-1:0] outst;
        sim_dev_queued #(.DEPTH(DP), .LATENCY(LT)) u_dut (
            .clock                  (clock),
            .reset                  (reset),
            .in_req_ready           (rdy[g]),
            .in_req_valid           (req_valid),
            .in_req_bits_is_cached  (cached),
            .in_req_bits_is_aligned (aligned),
            .in_req_bits_addr       (addr),
            .in_req_bits_data       (wdata),
            .in_req_bits_func       (func),
            .in_req_bits_wstrb      (wstrb),
            .in_resp_ready          (resp_ready),
            .in_resp_valid          (vld[g]),
            .in_resp_bits_data      (dat[g]),
            .outstanding            (outst)
        );
        assign outs[g] = 3'(outst);
    end

    typedef struct {
        logic        valid;
        logic [31:0] addr;
        logic        func;
        logic        rr;
        logic        e_ready;
        logic        e_valid;
        logic [31:0] e_data;
        logic [2:0]  e_out;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        int          edge_no;
    } exp_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic reset_all();
        reset      = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs [14];
        exp_t        q [$];
        logic [31:0] base;
        logic        exp_v;
        logic        do_push;
        logic        do_pop;
        int          issued;
        int          popped;
        int          ecnt;
        int          cycles;

        addr  = 32'h0;
        wdata = 32'hDEADBEEF;
        func  = 1'b0;
        wstrb = 4'hF;

        // valid, addr, func, resp_ready -> ready, valid, data, outstanding (instance 0)
        vecs[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 1'b1, 32'h101, 3'd1};
        vecs[1]  = '{1'b1, 32'h104, 1'b0, 1'b0, 1'b1, 1'b1, 32'h101, 3'd2};
        vecs[2]  = '{1'b1, 32'h108, 1'b1, 1'b1, 1'b1, 1'b1, 32'h105, 3'd2};
        vecs[3]  = '{1'b0, 32'h000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h000, 3'd1};
        vecs[4]  = '{1'b1, 32'h10C, 1'b0, 1'b1, 1'b1, 1'b1, 32'h10D, 3'd1};
        vecs[5]  = '{1'b0, 32'h000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h000, 3'd0};
        vecs[6]  = '{1'b1, 32'h001, 1'b0, 1'b0, 1'b1, 1'b1, 32'h002, 3'd1};
        vecs[7]  = '{1'b1, 32'h002, 1'b0, 1'b0, 1'b1, 1'b1, 32'h002, 3'd2};
        vecs[8]  = '{1'b1, 32'h003, 1'b0, 1'b0, 1'b1, 1'b1, 32'h002, 3'd3};
        vecs[9]  = '{1'b1, 32'h004, 1'b0, 1'b0, 1'b0, 1'b1, 32'h002, 3'd4};
        vecs[10] = '{1'b1, 32'h005, 1'b0, 1'b1, 1'b1, 1'b1, 32'h003, 3'd3};
        vecs[11] = '{1'b0, 32'h000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h004, 3'd2};
        vecs[12] = '{1'b0, 32'h000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h005, 3'd1};
        vecs[13] = '{1'b0, 32'h000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h000, 3'd0};

        reset_all();
        chk("rst_ready", 32'(rdy[0]), 32'd1);
        chk("rst_valid", 32'(vld[0]), 32'd0);
        chk("rst_data",  dat[0], 32'h0);
        chk("rst_out",   32'(outs[0]), 32'd0);

        base = g_dut[0].u_dut.io_calls_q;
        for (int i = 0; i < 14; i++) begin
            req_valid  = vecs[i].valid;
            addr       = vecs[i].addr;
            func       = vecs[i].func;
            resp_ready = vecs[i].rr;
            step();
            chk($sformatf("vec%0d_ready", i), 32'(rdy[0]), 32'(vecs[i].e_ready));
            chk($sformatf("vec%0d_valid", i), 32'(vld[0]), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d_data", i),  dat[0], vecs[i].e_data);
            chk($sformatf("vec%0d_out", i),   32'(outs[0]), 32'(vecs[i].e_out));
            if (i == 0) chk("t1_calls", g_dut[0].u_dut.io_calls_q - base, 32'd1);
        end
        req_valid = 1'b0;
        func      = 1'b0;
        chk("table_calls", g_dut[0].u_dut.io_calls_q - base, 32'd8);

        // Write: logged arguments and zero response data
        req_valid = 1'b1; func = 1'b1; addr = 32'h200; wdata = 32'hDEADBEEF; wstrb = 4'b0011;
        resp_ready = 1'b0;
        step();
        req_valid = 1'b0; func = 1'b0; wstrb = 4'hF;
        chk("t4_addr",  g_dut[0].u_dut.io_addr_q, 32'h200);
        chk("t4_data",  g_dut[0].u_dut.io_data_q, 32'hDEADBEEF);
        chk("t4_func",  32'(g_dut[0].u_dut.io_func_q), 32'h1);
        chk("t4_wstrb", 32'(g_dut[0].u_dut.io_wstrb_q), 32'h3);
        chk("t4_valid", 32'(vld[0]), 32'd1);
        chk("t4_rdata", dat[0], 32'h0);
        resp_ready = 1'b1;
        step();
        chk("t4_drain", 32'(outs[0]), 32'd0);

        // Reset with three requests in flight
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; addr = 32'h60 + 32'(i * 4);
            step();
        end
        chk("t5_pre_out", 32'(outs[0]), 32'd3);
        base = g_dut[0].u_dut.io_calls_q;
        reset = 1'b0; addr = 32'h50;
        step();
        chk("t5_valid", 32'(vld[0]), 32'd0);
        chk("t5_out",   32'(outs[0]), 32'd0);
        chk("t5_ready", 32'(rdy[0]), 32'd1);
        chk("t5_data",  dat[0], 32'h0);
        chk("t5_nocall", g_dut[0].u_dut.io_calls_q - base, 32'd0);
        reset = 1'b1; addr = 32'h40;
        step();
        req_valid = 1'b0;
        chk("t5_new_valid", 32'(vld[0]), 32'd1);
        chk("t5_new_data",  dat[0], 32'h41);
        chk("t5_new_out",   32'(outs[0]), 32'd1);
        chk("t5_new_calls", g_dut[0].u_dut.io_calls_q - base, 32'd1);

        // LATENCY=3: four back-to-back reads, then drain
        reset_all();
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; addr = 32'(i * 4);
            step();
            chk($sformatf("t2_valid%0d", i), 32'(vld[1]), (i >= 2) ? 32'd1 : 32'd0);
            chk($sformatf("t2_out%0d", i),   32'(outs[1]), 32'(i + 1));
        end
        req_valid = 1'b0;
        chk("t2_full_ready", 32'(rdy[1]), 32'd0);
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_rv%0d", i), 32'(vld[1]), 32'd1);
            chk($sformatf("t2_rd%0d", i), dat[1], 32'(i * 4 + 1));
            step();
        end
        chk("t2_empty", 32'(vld[1]), 32'd0);
        chk("t2_out_end", 32'(outs[1]), 32'd0);

        // DEPTH=2: full with response backpressure
        reset_all();
        base = g_dut[2].u_dut.io_calls_q;
        req_valid = 1'b1; addr = 32'h10;
        step();
        addr = 32'h14;
        step();
        addr = 32'h18;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("t3_hold_ready%0d", i), 32'(rdy[2]), 32'd0);
            chk($sformatf("t3_hold_out%0d", i),   32'(outs[2]), 32'd2);
            chk($sformatf("t3_hold_data%0d", i),  dat[2], 32'h11);
            step();
        end
        chk("t3_hold_calls", g_dut[2].u_dut.io_calls_q - base, 32'd2);
        resp_ready = 1'b1;
        step();
        chk("t3_pop1_out",   32'(outs[2]), 32'd1);
        chk("t3_pop1_data",  dat[2], 32'h15);
        chk("t3_pop1_ready", 32'(rdy[2]), 32'd1);
        step();
        req_valid = 1'b0;
        chk("t3_push_out",  32'(outs[2]), 32'd1);
        chk("t3_push_data", dat[2], 32'h19);
        step();
        chk("t3_end_out",   32'(outs[2]), 32'd0);
        chk("t3_calls",     g_dut[2].u_dut.io_calls_q - base, 32'd3);

        // DEPTH=3, LATENCY=2: ten reads under random response backpressure
        reset_all();
        issued = 0; popped = 0; ecnt = 0; cycles = 0;
        while ((issued < 10 || q.size() != 0) && cycles < 300) begin
            req_valid  = (issued < 10);
            addr       = 32'(issued * 4);
            resp_ready = (issued < 10) ? 1'($urandom_range(0, 1)) : 1'b1;
            exp_v      = (q.size() != 0) && (ecnt >= q[0].edge_no + 1);
            chk("t6_valid", 32'(vld[3]), 32'(exp_v));
            if (exp_v) chk("t6_data", dat[3], q[0].data);
            chk("t6_ready", 32'(rdy[3]), 32'(q.size() < 3));
            do_push = req_valid && (q.size() < 3);
            do_pop  = exp_v && resp_ready;
            step();
            ecnt++;
            cycles++;
            if (do_pop) begin
                void'(q.pop_front());
                popped++;
            end
            if (do_push) begin
                q.push_back('{32'(issued * 4 + 1), ecnt});
                issued++;
            end
            chk("t6_out", 32'(outs[3]), 32'(q.size()));
        end
        req_valid = 1'b0;
        chk("t6_popped", 32'(popped), 32'd10);
        chk("t6_issued", 32'(issued), 32'd10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sim_dev_queued.md
Name: sim_dev_queued

Overview:
Simulation-only memory/MMIO device model for the emulation SoC, driven through the DPI-C `device_io` call. It is the pipelined successor of the single-outstanding device model and accepts up to DEPTH outstanding requests. Each request is serviced at accept time, and its response is returned in order after a fixed LATENCY. It sits on the same `in_req`/`in_resp` ready-valid bus as the CPU memory port.

Parameters:
DEPTH, 4, maximum outstanding (accepted, not yet responded) requests; integer >= 1, any value, not only powers of two.
LATENCY, 1, minimum number of cycles from request accept edge to response valid; >= 1; LATENCY = 0 is an elaboration error.
CNT_W, $clog2(DEPTH+1), width of the outstanding counter (derived; not overridden).

Ports:
clock  input  1  sole clock; all state updates on posedge.
reset  input  1  synchronous, active-low reset (0 = in reset), sampled on posedge clock.
in_req_ready  output  1  request can be accepted this cycle.
in_req_valid  input  1  request valid.
in_req_bits_is_cached  input  1  ignored by the model.
in_req_bits_is_aligned  input  1  ignored by the model.
in_req_bits_addr  input  32  byte address.
in_req_bits_data  input  32  write data.
in_req_bits_func  input  1  0 = read, 1 = write.
in_req_bits_wstrb  input  4  byte write strobes.
in_resp_ready  input  1  consumer accepts the response.
in_resp_valid  output  1  head response available.
in_resp_bits_data  output  32  head response data.
outstanding  output  CNT_W  number of entries currently queued (debug).

Behaviour:
- Storage: circular queue of DEPTH entries, each holding {data[31:0], timer}.
  - Timer width: $clog2(LATENCY) bits, minimum 1.
  - Head and tail pointers wrap from DEPTH-1 to 0 explicitly, so non-power-of-two DEPTH is supported.
  - count holds 0..DEPTH.
- in_req_ready = (count < DEPTH). It is a function of registered count only, with no combinational path from in_resp_ready. When full, a same-cycle pop does not allow a push.
- Request fire = in_req_valid && in_req_ready && reset == 1 at posedge. On fire, in that clock edge:
  - call `device_io(1, addr, data, {7'b0, func}, {4'b0, wstrb}, rdata)`;
  - write {rdata, LATENCY-1} at tail; advance tail.
- `device_io` is called only on fire; it is never called with valid = 0, never twice for one request, and never in reset.
- Timers: every posedge, each occupied entry whose timer is nonzero decrements by 1. Timers saturate at 0.
- in_resp_valid = (count != 0) && (head timer == 0).
- in_resp_bits_data = head data when count != 0, else 32'h0.
- Response fire = in_resp_valid && in_resp_ready: pop the head and advance head.
- Latency: a request accepted at edge N has in_resp_valid asserted in the cycle following edge N+LATENCY-1, unless older entries are still queued ahead of it. With LATENCY = 1, a response is visible the cycle after acceptance.
- Ordering: responses are returned strictly in acceptance order. A younger entry whose timer has reached 0 waits behind the head.
- Response backpressure: while in_resp_ready = 0, the head stays valid with stable data. Younger timers keep counting down.
- Simultaneous push and pop (count between 1 and DEPTH-1): count is unchanged, both pointers advance. With count == 0, a push cannot pop in the same cycle.
- outstanding = count, registered.
- Reset (reset == 0 at posedge): count, head and tail go to 0 and entries are invalidated. No DPI call is made and in-flight responses are dropped. This holds mid-operation too.
- Output values during and after reset: in_req_ready = 1, in_resp_valid = 0, in_resp_bits_data = 0, outstanding = 0.
- Behaviour when in_req_valid is deasserted without fire is unconstrained. No protocol checking is performed.

Test Plan:
1. Bench stub: `device_io` returns addr+1 for reads and 0 for writes, and logs calls. LATENCY=1, DEPTH=4: read addr 0x100 at edge 0 -> in_resp_valid high in cycle 1, data 0x101; exactly 1 DPI call.
2. LATENCY=3, DEPTH=4: 4 back-to-back reads 0x0, 0x4, 0x8, 0xC with in_resp_ready=1.
   - in_req_ready drops after 4th accept.
   - First response appears 3 cycles after the first accept; data 0x1, 0x5, 0x9, 0xD in order on consecutive cycles.
3. Full plus backpressure: DEPTH=2, in_resp_ready=0, issue 3 reads.
   - Third request is held with in_req_ready=0; outstanding=2.
   - Head data stays stable.
   - Raise in_resp_ready: one pop per cycle; third request is accepted only after count<2; DPI call count = 3.
4. Write: func=1, addr 0x200, data 0xDEADBEEF, wstrb 4'b0011 -> stub logs these exact args; response data 0x0 after LATENCY.
5. Reset mid-flight: 3 requests outstanding, assert reset=0 for 1 cycle.
   - in_resp_valid=0, outstanding=0, in_req_ready=1; no DPI call in the reset cycle.
   - New read 0x40 then returns 0x41.
6. Non-power-of-two DEPTH=3, LATENCY=2: 10 reads with random in_resp_ready -> all responses in order with correct data.
   - Pointer wrap is exercised at least 3 times; outstanding never exceeds 3.
